// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, registered outputs.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int   CLKS_PER_BIT = 10416,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PENULT = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= IDLE_LEVEL;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (tx_valid) begin
                        shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= START;
                    end
                end

                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // shift_reg[0] always holds the next bit to go out
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= IDLE_LEVEL;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx       <= IDLE_LEVEL;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                // done is registered one cycle early so it lands on the last stop cycle
                STOP: begin
                    tx <= IDLE_LEVEL;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tx_done  <= (baud_cnt == BAUD_PENULT);
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= IDLE_LEVEL;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
